// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    STOP,
    DONE
  } state_e;

  localparam int unsigned SLOTS       = 27;
  localparam int unsigned START_TICKS = 2;
  localparam int unsigned STOP_TICKS  = 3;

  localparam logic [7:0] AUDIO_ADDR = 8'h34;
  localparam logic [7:0] VIDEO_ADDR = 8'h40;

  // CLOCK_50 cycles per quarter SCL period.
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit clock-enable generator: wrapping counter with sync clear and enable.
module i2c_tick_gen #(
  parameter int unsigned DIV = 625
) (
  input  logic CLOCK_50,
  input  logic iRST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && !i_clr && w_last;

endmodule

// File: rtl/i2c_write_engine.sv
// Single-transaction I2C master: START, 3 bytes with ACK slots, STOP, per GO handshake.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned I2C_FREQ = 20_000,
  parameter int unsigned TICK_DIV = tick_div(CLK_FREQ, I2C_FREQ)
) (
  input  logic        CLOCK_50,
  input  logic        iRST_N,
  input  logic [23:0] i_data,
  input  logic        i_go,
  output logic        o_busy,
  output logic        o_end,
  output logic        o_nack,
  output logic        FPGA_I2C_SCLK,
  inout  wire         FPGA_I2C_SDAT
);

  state_e      r_state;
  logic [23:0] r_shift;
  logic [4:0]  r_slot;
  logic [3:0]  r_bit;
  logic [1:0]  r_phase;
  logic [1:0]  r_step;
  logic        r_scl;
  logic        r_sda_low;
  logic        r_busy;
  logic        r_end;
  logic        r_nack;
  logic [1:0]  r_sda_sync;

  logic        w_tick;
  logic        w_accept;
  logic        w_ack_slot;

  assign w_accept   = (r_state == IDLE) && i_go;
  assign w_ack_slot = (r_bit == 4'd8);

  i2c_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .i_clr    (w_accept),
    .i_en     (r_busy),
    .o_tick   (w_tick)
  );

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sda_sync <= 2'b11;
    end else begin
      r_sda_sync <= {r_sda_sync[0], FPGA_I2C_SDAT};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_slot    <= '0;
      r_bit     <= '0;
      r_phase   <= '0;
      r_step    <= '0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_go) begin
            r_shift <= i_data;
            r_nack  <= 1'b0;
            r_busy  <= 1'b1;
            r_step  <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_step == 2'(START_TICKS - 1)) begin
              r_scl   <= 1'b0;
              r_step  <= '0;
              r_slot  <= '0;
              r_bit   <= '0;
              r_phase <= '0;
              r_state <= BITS;
            end else begin
              r_sda_low <= 1'b1;
              r_step    <= r_step + 2'd1;
            end
          end
        end
        BITS: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            unique case (r_phase)
              2'd0: r_sda_low <= w_ack_slot ? 1'b0 : ~r_shift[23];
              2'd1: r_scl <= 1'b1;
              2'd2: begin
                if (w_ack_slot && r_sda_sync[1]) r_nack <= 1'b1;
              end
              2'd3: begin
                r_scl <= 1'b0;
                if (w_ack_slot) begin
                  r_bit <= '0;
                end else begin
                  r_bit   <= r_bit + 4'd1;
                  r_shift <= {r_shift[22:0], 1'b0};
                end
                if (r_slot == 5'(SLOTS - 1)) begin
                  r_step  <= '0;
                  r_state <= STOP;
                end else begin
                  r_slot <= r_slot + 5'd1;
                end
              end
              default: ;
            endcase
          end
        end
        STOP: begin
          // One extra cycle after the final STOP tick before reporting completion.
          if (r_step == 2'(STOP_TICKS)) begin
            r_busy  <= 1'b0;
            r_end   <= 1'b1;
            r_state <= DONE;
          end else if (w_tick) begin
            r_step <= r_step + 2'd1;
            unique case (r_step)
              2'd0:    r_sda_low <= 1'b1;
              2'd1:    r_scl     <= 1'b1;
              default: r_sda_low <= 1'b0;
            endcase
          end
        end
        DONE: begin
          if (!i_go) begin
            r_end   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_end         = r_end;
  assign o_nack        = r_nack;
  assign FPGA_I2C_SCLK = r_scl;
  assign FPGA_I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed + random bench for i2c_write_engine with a bus-level slave model.
module tb_i2c_write_engine;
  import i2c_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned LAT = 113 * TD + 1;

  logic        CLOCK_50 = 1'b0;
  logic        iRST_N   = 1'b0;
  logic [23:0] i_data   = '0;
  logic        i_go     = 1'b0;
  logic        o_busy;
  logic        o_end;
  logic        o_nack;
  logic        scl;
  wire         sda;

  logic        slv_low = 1'b0;
  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 CLOCK_50 = ~CLOCK_50;

  i2c_write_engine #(
    .CLK_FREQ (400),
    .I2C_FREQ (25)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .iRST_N        (iRST_N),
    .i_data        (i_data),
    .i_go          (i_go),
    .o_busy        (o_busy),
    .o_end         (o_end),
    .o_nack        (o_nack),
    .FPGA_I2C_SCLK (scl),
    .FPGA_I2C_SDAT (sda)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Slave model: decodes START/STOP/bytes and drives ACK per nack_mask bit.
  logic [2:0] nack_mask = '0;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  int         starts    = 0;
  int         stops     = 0;
  int         bitcnt    = 0;
  logic [7:0] cur       = '0;
  logic [7:0] got[$];

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (scl && prev_scl && prev_sda && !sda) begin
        starts++;
        bitcnt = 0;
        got.delete();
      end else if (scl && prev_scl && !prev_sda && sda) begin
        stops++;
      end else if (scl && !prev_scl) begin
        if (bitcnt < 8) cur = {cur[6:0], sda};
        bitcnt++;
      end else if (!scl && prev_scl) begin
        if (bitcnt == 8) begin
          slv_low = (got.size() < 3) ? !nack_mask[got.size()] : 1'b0;
        end else if (bitcnt == 9) begin
          slv_low = 1'b0;
          got.push_back(cur);
          bitcnt = 0;
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [23:0] d, input logic [2:0] mask, input string tag);
    int         cyc;
    int         s0;
    int         p0;
    logic [7:0] exp_b[3];
    exp_b[0]  = d[23:16];
    exp_b[1]  = d[15:8];
    exp_b[2]  = d[7:0];
    nack_mask = mask;
    s0 = starts;
    p0 = stops;
    @(negedge CLOCK_50);
    i_data = d;
    i_go   = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check({tag, "_busy_on_accept"}, 32'(o_busy), 32'd1);
    check({tag, "_nack_cleared"}, 32'(o_nack), 32'd0);
    cyc = 0;
    while (!o_end && cyc < 4 * LAT) begin
      i_data = 24'($urandom);
      @(posedge CLOCK_50);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_nack"}, 32'(o_nack), 32'(|mask));
    check({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    check({tag, "_starts"}, 32'(starts - s0), 32'd1);
    check({tag, "_stops"}, 32'(stops - p0), 32'd1);
    check({tag, "_nbytes"}, 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) check({tag, "_byte"}, 32'(got[i]), 32'(exp_b[i]));
    end
    check({tag, "_scl_idle"}, 32'(scl), 32'd1);
    check({tag, "_sda_idle"}, 32'(sda), 32'd1);
  endtask

  task automatic finish_txn(input int hold, input string tag);
    int s0;
    int bad;
    s0  = starts;
    bad = 0;
    repeat (hold) begin
      @(posedge CLOCK_50);
      #1;
      if (o_end !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check({tag, "_end_held"}, 32'(bad), 32'd0);
    check({tag, "_no_restart"}, 32'(starts - s0), 32'd0);
    @(negedge CLOCK_50);
    i_go = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check({tag, "_end_drop"}, 32'(o_end), 32'd0);
  endtask

  task automatic clear_model();
    slv_low = 1'b0;
    bitcnt  = 0;
    got.delete();
  endtask

  initial begin
    int         cyc;
    logic [23:0] d;
    logic [2:0]  m;

    // Reset held with random go: outputs at reset values and no bus activity.
    for (int i = 0; i < 10; i++) begin
      i_go = 1'($urandom);
      @(negedge CLOCK_50);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_end", 32'(o_end), 32'd0);
      check("rst_nack", 32'(o_nack), 32'd0);
    end
    check("rst_no_start", 32'(starts), 32'd0);
    i_go = 1'b0;
    @(negedge CLOCK_50);
    iRST_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    run_txn({AUDIO_ADDR, 8'h0E, 8'h17}, 3'b000, "normal");
    finish_txn(5, "normal");

    run_txn({VIDEO_ADDR, 8'h15, 8'h00}, 3'b010, "nack");
    finish_txn(100, "hs");

    run_txn(24'h34_0C00, 3'b000, "second");
    finish_txn(3, "second");

    for (int k = 0; k < 4; k++) begin
      d = 24'($urandom);
      m = 3'($urandom_range(0, 7));
      run_txn(d, m, "rand");
      finish_txn(2, "rand");
    end

    // Asynchronous reset in the middle of slot 12 (byte 1, fourth data bit).
    nack_mask = '0;
    @(negedge CLOCK_50);
    i_data = {AUDIO_ADDR, 8'hA5, 8'h5A};
    i_go   = 1'b1;
    cyc    = 0;
    while (!(got.size() == 1 && bitcnt == 4) && cyc < 4 * LAT) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check("abort_reached_slot12", 32'(cyc < 4 * LAT), 32'd1);
    #2;
    iRST_N = 1'b0;
    #1;
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_sda", 32'(sda), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_end", 32'(o_end), 32'd0);
    i_go = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    clear_model();
    iRST_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    run_txn({VIDEO_ADDR, 8'h33, 8'hC1}, 3'b000, "post_rst");
    finish_txn(2, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
